// File: rtl/univ_shift_reg.sv
// Universal shift register: hold, shift right/left and parallel load, with a WIDTH-shift word counter.
// Latency: outputs are direct register views (zero added latency); word_done is registered, one cycle after the last shift.
// Backpressure: none; en=0 freezes the register and counter and keeps word_done low.
module univ_shift_reg #(
    parameter int                 WIDTH     = 8,
    parameter logic [WIDTH-1:0]   RESET_VAL = '0,
    parameter int                 CNT_W     = $clog2(WIDTH + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic [1:0]        mode,
    input  logic              serial_in,
    input  logic [WIDTH-1:0]  parallel_in,
    output logic [WIDTH-1:0]  parallel_out,
    output logic              serial_out_lsb,
    output logic              serial_out_msb,
    output logic [CNT_W-1:0]  shift_cnt,
    output logic              word_done
);

    localparam logic [1:0] MODE_HOLD  = 2'b00;
    localparam logic [1:0] MODE_RIGHT = 2'b01;
    localparam logic [1:0] MODE_LEFT  = 2'b10;
    localparam logic [1:0] MODE_LOAD  = 2'b11;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    logic [WIDTH-1:0] q;
    logic [CNT_W-1:0] cnt;
    logic             done;
    logic             is_shift;
    logic [CNT_W-1:0] cnt_next;
    logic             wrap;

    assign is_shift = en && ((mode == MODE_RIGHT) || (mode == MODE_LEFT));
    assign wrap     = (cnt == CNT_LAST);
    assign cnt_next = wrap ? '0 : cnt + CNT_W'(1);

    always_ff @(posedge clk) begin
        if (rst) begin
            q    <= RESET_VAL;
            cnt  <= '0;
            done <= 1'b0;
        end else begin
            done <= 1'b0;
            if (en) begin
                case (mode)
                    MODE_RIGHT: q <= {serial_in, q[WIDTH-1:1]};
                    MODE_LEFT:  q <= {q[WIDTH-2:0], serial_in};
                    MODE_LOAD:  q <= parallel_in;
                    default:    q <= q;
                endcase
                if (mode == MODE_LOAD) begin
                    cnt <= '0;
                end else if (is_shift) begin
                    // Direction changes mid-word still count toward the same word.
                    cnt  <= cnt_next;
                    done <= wrap;
                end
            end
        end
    end

    assign parallel_out   = q;
    assign serial_out_lsb = q[0];
    assign serial_out_msb = q[WIDTH-1];
    assign shift_cnt      = cnt;
    assign word_done      = done;

endmodule
